// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps note-on/note-off events onto a bank of oscillator voices,
// reusing a matching voice first, then the lowest free voice, then stealing the oldest.
module voice_allocator #(
  parameter int VOICES = 8,
  parameter int WIDTH  = 24,
  parameter int KEY_W  = 7,
  parameter int AGE_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ev_valid,
  output logic                          ev_ready,
  input  logic                          ev_on,
  input  logic [KEY_W-1:0]              ev_key,
  input  logic [15:0]                   ev_freq,
  input  logic [WIDTH-1:0]              ev_amp,
  input  logic                          panic,
  output logic [VOICES-1:0]             voice_enable,
  output logic [VOICES*16-1:0]          voice_freq,
  output logic [VOICES*WIDTH-1:0]       voice_amp,
  output logic [$clog2(VOICES+1)-1:0]   active_count,
  output logic                          steal_pulse
);

  localparam int IDX_W = $clog2(VOICES);
  localparam int CNT_W = $clog2(VOICES+1);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SCAN    = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;
  localparam logic [1:0] RESTART = 2'd3;

  logic [1:0]       state;
  logic             started;
  logic [IDX_W-1:0] idx;
  logic             lat_on;
  logic [KEY_W-1:0] lat_key;
  logic [15:0]      lat_freq;
  logic [WIDTH-1:0] lat_amp;

  logic             match_found, free_found, old_found;
  logic [IDX_W-1:0] match_idx, free_idx, old_idx, restart_idx;
  logic [AGE_W-1:0] old_age;

  logic [KEY_W-1:0] voice_key [VOICES];
  logic [AGE_W-1:0] voice_age [VOICES];

  logic [IDX_W-1:0] commit_tgt;
  logic             commit_steal;
  logic             commit_restart;
  logic [VOICES-1:0] en_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // started delays ev_ready by one edge after reset release
  assign ev_ready = (state == IDLE) && started && !panic;

  always_comb begin
    commit_tgt     = match_found ? match_idx : (free_found ? free_idx : old_idx);
    commit_steal   = lat_on && !match_found && !free_found;
    commit_restart = lat_on && (match_found || !free_found);
    en_nxt         = voice_enable;
    if (panic) begin
      en_nxt = '0;
    end else if (state == COMMIT) begin
      if (lat_on) begin
        en_nxt[commit_tgt] = !commit_restart;
      end else if (match_found) begin
        en_nxt[match_idx] = 1'b0;
      end
    end else if (state == RESTART) begin
      en_nxt[restart_idx] = 1'b1;
    end
    cnt_nxt = '0;
    for (int v = 0; v < VOICES; v++) begin
      cnt_nxt = cnt_nxt + CNT_W'(en_nxt[v]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      started      <= 1'b0;
      idx          <= '0;
      lat_on       <= 1'b0;
      lat_key      <= '0;
      lat_freq     <= '0;
      lat_amp      <= '0;
      match_found  <= 1'b0;
      free_found   <= 1'b0;
      old_found    <= 1'b0;
      match_idx    <= '0;
      free_idx     <= '0;
      old_idx      <= '0;
      old_age      <= '0;
      restart_idx  <= '0;
      voice_enable <= '0;
      voice_freq   <= '0;
      voice_amp    <= '0;
      active_count <= '0;
      steal_pulse  <= 1'b0;
      for (int v = 0; v < VOICES; v++) begin
        voice_key[v] <= '0;
        voice_age[v] <= '0;
      end
    end else begin
      started      <= 1'b1;
      steal_pulse  <= 1'b0;
      voice_enable <= en_nxt;
      active_count <= cnt_nxt;
      if (panic) begin
        state <= IDLE;
        for (int v = 0; v < VOICES; v++) begin
          voice_age[v] <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (ev_valid && ev_ready) begin
              lat_on      <= ev_on;
              lat_key     <= ev_key;
              lat_freq    <= ev_freq;
              lat_amp     <= ev_amp;
              idx         <= '0;
              match_found <= 1'b0;
              free_found  <= 1'b0;
              old_found   <= 1'b0;
              state       <= SCAN;
            end
          end
          SCAN: begin
            // Strict '>' keeps the lowest index among equally old voices
            if (voice_enable[idx]) begin
              if (!match_found && voice_key[idx] == lat_key) begin
                match_found <= 1'b1;
                match_idx   <= idx;
              end
              if (!old_found || voice_age[idx] > old_age) begin
                old_found <= 1'b1;
                old_idx   <= idx;
                old_age   <= voice_age[idx];
              end
            end else if (!free_found) begin
              free_found <= 1'b1;
              free_idx   <= idx;
            end
            idx <= idx + 1'b1;
            if (idx == IDX_W'(VOICES-1)) state <= COMMIT;
          end
          COMMIT: begin
            state <= IDLE;
            if (lat_on) begin
              for (int v = 0; v < VOICES; v++) begin
                if (IDX_W'(v) == commit_tgt) begin
                  voice_key[v]                 <= lat_key;
                  voice_age[v]                 <= '0;
                  voice_freq[16*v +: 16]       <= lat_freq;
                  voice_amp[WIDTH*v +: WIDTH]  <= lat_amp;
                end else if (voice_enable[v] && voice_age[v] != AGE_MAX) begin
                  voice_age[v] <= voice_age[v] + 1'b1;
                end
              end
              steal_pulse <= commit_steal;
              restart_idx <= commit_tgt;
              if (commit_restart) state <= RESTART;
            end
          end
          RESTART: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios followed by random events,
// compared against a voice-table reference model kept in plain arrays.
module tb_voice_allocator;

  localparam int VOICES = 8;
  localparam int WIDTH  = 24;
  localparam int KEY_W  = 7;
  localparam int AGE_W  = 8;
  localparam int CNT_W  = $clog2(VOICES+1);
  localparam int AGE_SAT = (1 << AGE_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     ev_valid = 1'b0;
  logic                     ev_ready;
  logic                     ev_on = 1'b0;
  logic [KEY_W-1:0]         ev_key = '0;
  logic [15:0]              ev_freq = '0;
  logic [WIDTH-1:0]         ev_amp = '0;
  logic                     panic = 1'b0;
  logic [VOICES-1:0]        voice_enable;
  logic [VOICES*16-1:0]     voice_freq;
  logic [VOICES*WIDTH-1:0]  voice_amp;
  logic [CNT_W-1:0]         active_count;
  logic                     steal_pulse;

  voice_allocator #(.VOICES(VOICES), .WIDTH(WIDTH), .KEY_W(KEY_W), .AGE_W(AGE_W)) dut (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
    .ev_key(ev_key), .ev_freq(ev_freq), .ev_amp(ev_amp), .panic(panic),
    .voice_enable(voice_enable), .voice_freq(voice_freq), .voice_amp(voice_amp),
    .active_count(active_count), .steal_pulse(steal_pulse)
  );

  always #5 clk = ~clk;

  bit               m_en   [VOICES];
  int               m_key  [VOICES];
  int               m_age  [VOICES];
  logic [15:0]      m_freq [VOICES];
  logic [WIDTH-1:0] m_amp  [VOICES];

  int checks = 0;
  int failures = 0;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input bit exp_steal);
    int cnt = 0;
    for (int v = 0; v < VOICES; v++) begin
      checkVal($sformatf("%s en%0d", tag, v), 64'(voice_enable[v]), 64'(m_en[v]));
      checkVal($sformatf("%s freq%0d", tag, v), 64'(voice_freq[16*v +: 16]), 64'(m_freq[v]));
      checkVal($sformatf("%s amp%0d", tag, v), 64'(voice_amp[WIDTH*v +: WIDTH]), 64'(m_amp[v]));
      cnt += int'(m_en[v]);
    end
    checkVal({tag, " count"}, 64'(active_count), 64'(cnt));
    checkVal({tag, " steal"}, 64'(steal_pulse), 64'(exp_steal));
  endtask

  function automatic int findMatch(input int key);
    for (int v = 0; v < VOICES; v++) if (m_en[v] && m_key[v] == key) return v;
    return -1;
  endfunction

  function automatic int findFree();
    for (int v = 0; v < VOICES; v++) if (!m_en[v]) return v;
    return -1;
  endfunction

  function automatic int findOldest();
    int best = -1;
    for (int v = 0; v < VOICES; v++)
      if (m_en[v] && (best < 0 || m_age[v] > m_age[best])) best = v;
    return best;
  endfunction

  task automatic modelReset();
    for (int v = 0; v < VOICES; v++) begin
      m_en[v] = 0; m_key[v] = 0; m_age[v] = 0; m_freq[v] = '0; m_amp[v] = '0;
    end
  endtask

  task automatic modelPanic();
    for (int v = 0; v < VOICES; v++) begin
      m_en[v] = 0; m_age[v] = 0;
    end
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while (ev_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkVal({tag, " ready"}, 64'(ev_ready), 64'd1);
  endtask

  // Issues one event and follows it through scan, commit and optional restart.
  task automatic applyStimulus(input bit on, input int key, input logic [15:0] freq,
                               input logic [WIDTH-1:0] amp, input string tag);
    int mi, fi, oi, tgt;
    bit restart = 0;
    bit steal = 0;
    waitReady(tag);
    ev_valid = 1'b1; ev_on = on; ev_key = KEY_W'(key); ev_freq = freq; ev_amp = amp;
    @(posedge clk);
    @(negedge clk);
    ev_valid = 1'b0;
    checkVal({tag, " busy"}, 64'(ev_ready), 64'd0);
    repeat (VOICES) @(negedge clk);
    checkOutput({tag, " pre"}, 1'b0);
    mi = findMatch(key);
    if (on) begin
      fi = findFree();
      oi = findOldest();
      tgt = (mi >= 0) ? mi : ((fi >= 0) ? fi : oi);
      restart = (mi >= 0) || (fi < 0);
      steal = (mi < 0) && (fi < 0);
      for (int v = 0; v < VOICES; v++)
        if (v != tgt && m_en[v] && m_age[v] < AGE_SAT) m_age[v]++;
      m_key[tgt] = key; m_freq[tgt] = freq; m_amp[tgt] = amp; m_age[tgt] = 0;
      m_en[tgt] = !restart;
    end else begin
      tgt = mi;
      if (mi >= 0) m_en[mi] = 0;
    end
    @(negedge clk);
    checkOutput({tag, " commit"}, steal);
    if (restart) begin
      m_en[tgt] = 1;
      @(negedge clk);
      checkOutput({tag, " restart"}, 1'b0);
    end
    checkVal({tag, " idle"}, 64'(ev_ready), 64'd1);
  endtask

  task automatic doPanic(input string tag);
    panic = 1'b1;
    #1;
    checkVal({tag, " ready"}, 64'(ev_ready), 64'd0);
    @(negedge clk);
    modelPanic();
    checkOutput(tag, 1'b0);
    panic = 1'b0;
  endtask

  initial begin
    $display("[TB] voice_allocator bench start");
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset", 1'b0);
    checkVal("reset ready", 64'(ev_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    checkVal("release ready", 64'(ev_ready), 64'd0);
    @(negedge clk);
    checkVal("first edge ready", 64'(ev_ready), 64'd1);

    applyStimulus(1'b1, 60, 16'd440, 24'h400000, "t1");
    checkVal("t1 freq0", 64'(voice_freq[15:0]), 64'd440);

    for (int k = 61; k <= 67; k++)
      applyStimulus(1'b1, k, 16'(100 + k), 24'(k * 1000), $sformatf("t2 on%0d", k));
    applyStimulus(1'b1, 72, 16'd880, 24'h123456, "t2 steal");
    checkVal("t2 freq0", 64'(voice_freq[15:0]), 64'd880);
    doPanic("t2 panic");

    applyStimulus(1'b1, 60, 16'd500, 24'h100000, "t3 first");
    applyStimulus(1'b1, 60, 16'd500, 24'h200000, "t3 retrig");
    checkVal("t3 amp0", 64'(voice_amp[WIDTH-1:0]), 64'h200000);
    doPanic("t3 panic");

    applyStimulus(1'b1, 60, 16'd261, 24'h010000, "t4 on60");
    applyStimulus(1'b1, 61, 16'd277, 24'h020000, "t4 on61");
    applyStimulus(1'b1, 62, 16'd293, 24'h030000, "t4 on62");
    applyStimulus(1'b0, 61, 16'd0, 24'h0, "t4 off61");
    applyStimulus(1'b1, 70, 16'd466, 24'h040000, "t4 on70");
    checkVal("t4 reuse en1", 64'(voice_enable[1]), 64'd1);
    checkVal("t4 reuse freq1", 64'(voice_freq[31:16]), 64'd466);

    applyStimulus(1'b0, 99, 16'd0, 24'h0, "t5 off99");

    waitReady("t6 scan");
    ev_valid = 1'b1; ev_on = 1'b1; ev_key = 7'd80; ev_freq = 16'd999; ev_amp = 24'h777777;
    @(negedge clk);
    ev_valid = 1'b0;
    repeat (3) @(negedge clk);
    doPanic("t6 panic");
    repeat (VOICES + 4) @(negedge clk);
    checkOutput("t6 dropped", 1'b0);
    checkVal("t6 ready", 64'(ev_ready), 64'd1);

    applyStimulus(1'b1, 40, 16'd110, 24'h000111, "t6 on40");
    applyStimulus(1'b1, 41, 16'd120, 24'h000222, "t6 on41");
    applyStimulus(1'b1, 42, 16'd130, 24'h000333, "t6 on42");
    waitReady("t6 commit");
    ev_valid = 1'b1; ev_on = 1'b1; ev_key = 7'd90; ev_freq = 16'd1234; ev_amp = 24'h555555;
    @(negedge clk);
    ev_valid = 1'b0;
    repeat (VOICES) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("t6 arst", 1'b0);
    checkVal("t6 arst ready", 64'(ev_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("t6 rerelease ready", 64'(ev_ready), 64'd1);

    for (int i = 0; i < 80; i++) begin
      if (i % 20 == 19) begin
        doPanic($sformatf("rnd%0d panic", i));
      end else begin
        applyStimulus(($urandom_range(0, 3) != 0), 60 + int'($urandom_range(0, 11)),
                      16'($urandom), 24'($urandom), $sformatf("rnd%0d", i));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
